// File: rtl/serpent_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// serpent_round_ctrl_if
//
// Bundles every handshake and data signal of the Serpent round controller.
// The clock and reset are not part of the bundle; they stay plain ports on
// the engine.
//
//   Plaintext side : in_valid / in_ready, x0..x3 (32-bit bit-slices)
//   Key side       : key_req / key_idx (0..32) / key_ack, k0..k3
//   Ciphertext side: out_valid / out_ready, y0..y3
//   Status         : busy (engine in RUN or DONE)
//
// Modports:
//   slave  - the engine (serpent_round_ctrl)
//   master - the surroundings: block-cipher front end plus key-schedule RAM
// ---------------------------------------------------------------------------
interface serpent_round_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x0;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [31:0] x3;

  logic        key_req;
  logic [5:0]  key_idx;
  logic        key_ack;
  logic [31:0] k0;
  logic [31:0] k1;
  logic [31:0] k2;
  logic [31:0] k3;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] y0;
  logic [31:0] y1;
  logic [31:0] y2;
  logic [31:0] y3;

  logic        busy;

  modport slave (
    input  in_valid, x0, x1, x2, x3,
    input  key_ack, k0, k1, k2, k3,
    input  out_ready,
    output in_ready, key_req, key_idx,
    output out_valid, y0, y1, y2, y3,
    output busy
  );

  modport master (
    output in_valid, x0, x1, x2, x3,
    output key_ack, k0, k1, k2, k3,
    output out_ready,
    input  in_ready, key_req, key_idx,
    input  out_valid, y0, y1, y2, y3,
    input  busy
  );
endinterface

// File: rtl/serpent_round_ctrl.sv
// ---------------------------------------------------------------------------
// serpent_round_ctrl
//
// Iterative bit-sliced Serpent-128 encryption engine. One plaintext block is
// taken over a valid/ready handshake. The engine then fetches the 33 subkeys
// one at a time over a request/acknowledge port and runs 32 rounds through a
// single shared S-box stage (box = round mod 8) and the linear transform.
// The ciphertext is returned over a second valid/ready handshake.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - synchronous active-high reset
//   abort  - (only with SERPENT_CTRL_ABORT_EN) drop the current block
//   bus    - serpent_round_ctrl_if.slave (plaintext, subkey and ciphertext
//            handshakes, busy flag)
//
// Build option:
//   SERPENT_CTRL_ABORT_EN - adds the abort input. Abort in RUN or DONE
//                           returns the engine to IDLE with X and the round
//                           counter cleared. It wins over key_ack and
//                           out_ready, and is ignored in IDLE.
// ---------------------------------------------------------------------------
module serpent_round_ctrl (
  input  logic                clk,
  input  logic                rst,
`ifdef SERPENT_CTRL_ABORT_EN
  input  logic                abort,
`endif
  serpent_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Round 31 skips the linear transform. Round 32 is only the final key
  // whitening step.
  localparam logic [5:0] LAST_SBOX_ROUND = 6'd31;
  localparam logic [5:0] WHITEN_ROUND    = 6'd32;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_next;
  logic [3:0][31:0] r_x;          // [n] holds slice Xn
  logic [3:0][31:0] w_x_next;
  logic [5:0]       r_round;
  logic [5:0]       w_round_next;

  // -------------------------------------------------------------------------
  // Datapath wires
  // -------------------------------------------------------------------------
  logic [3:0][31:0] w_in;         // plaintext slices
  logic [3:0][31:0] w_k;          // subkey slices
  logic [3:0][31:0] w_t;          // X ^ K
  logic [3:0][31:0] w_s;          // S-box output
  logic [3:0][31:0] w_lt;         // linear transform output
  logic             w_abort;

  // Output values before they are driven onto the interface.
  logic             w_in_ready;
  logic             w_key_req;
  logic [5:0]       w_key_idx;
  logic             w_out_valid;
  logic [3:0][31:0] w_y;
  logic             w_busy;

  assign w_in = {bus.x3, bus.x2, bus.x1, bus.x0};
  assign w_k  = {bus.k3, bus.k2, bus.k1, bus.k0};
  assign w_t  = r_x ^ w_k;

`ifdef SERPENT_CTRL_ABORT_EN
  assign w_abort = abort && (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  function automatic logic [31:0] rotl32(input logic [31:0] v, input int amt);
    return (v << amt) | (v >> (32 - amt));
  endfunction

  // Each table is written with the entry for input 0 in the top nibble, so
  // the entry for input v sits at bit offset 4*(15-v) = {~v, 2'b00}.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] sel,
                                             input logic [3:0] v);
    logic [63:0] tab;
    case (sel)
      3'd0:    tab = 64'h38F1A65BED42709C;
      3'd1:    tab = 64'hFC27905A1BE86D34;
      3'd2:    tab = 64'h86793CAFD1E40B52;
      3'd3:    tab = 64'h0FB8C963D124A75E;
      3'd4:    tab = 64'h1F83C0B6254A9E7D;
      3'd5:    tab = 64'hF52B4A9C03E8D671;
      3'd6:    tab = 64'h72C5846BE91FD3A0;
      default: tab = 64'h1DF0E82B74CA9356;
    endcase
    return tab[{~v, 2'b00} +: 4];
  endfunction

  // -------------------------------------------------------------------------
  // Shared S-box stage. The column at bit position gi forms the nibble
  // {T3,T2,T1,T0}. Output bit n goes back to slice n. The box is picked by
  // the low three bits of the round counter. For round 31 this is S7, which
  // is the box needed for the last substitution.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_sbox
      logic [3:0] w_nib_in;
      logic [3:0] w_nib_out;
      assign w_nib_in  = {w_t[3][gi], w_t[2][gi], w_t[1][gi], w_t[0][gi]};
      assign w_nib_out = sbox_lookup(r_round[2:0], w_nib_in);
      assign w_s[0][gi] = w_nib_out[0];
      assign w_s[1][gi] = w_nib_out[1];
      assign w_s[2][gi] = w_nib_out[2];
      assign w_s[3][gi] = w_nib_out[3];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Linear transform, written out as a chain of named intermediate steps.
  // -------------------------------------------------------------------------
  logic [31:0] w_a0;
  logic [31:0] w_a2;
  logic [31:0] w_b1;
  logic [31:0] w_b3;
  logic [31:0] w_c1;
  logic [31:0] w_c3;
  logic [31:0] w_d0;
  logic [31:0] w_d2;

  assign w_a0 = rotl32(w_s[0], 13);
  assign w_a2 = rotl32(w_s[2], 3);
  assign w_b1 = w_s[1] ^ w_a0 ^ w_a2;
  assign w_b3 = w_s[3] ^ w_a2 ^ (w_a0 << 3);
  assign w_c1 = rotl32(w_b1, 1);
  assign w_c3 = rotl32(w_b3, 7);
  assign w_d0 = w_a0 ^ w_c1 ^ w_c3;
  assign w_d2 = w_a2 ^ w_c3 ^ (w_c1 << 7);
  assign w_lt = {w_c3, rotl32(w_d2, 22), w_c1, rotl32(w_d0, 5)};

  // -------------------------------------------------------------------------
  // FSM process 1: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_round <= '0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_round <= w_round_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_round_next = r_round;

    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_x_next     = w_in;
          w_round_next = 6'd0;
          w_state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        // A cycle without key_ack leaves everything as it is.
        if (bus.key_ack) begin
          if (r_round == WHITEN_ROUND) begin
            w_x_next     = w_t;
            w_state_next = ST_DONE;
          end else if (r_round == LAST_SBOX_ROUND) begin
            w_x_next     = w_s;
            w_round_next = r_round + 6'd1;
          end else begin
            w_x_next     = w_lt;
            w_round_next = r_round + 6'd1;
          end
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the handshakes asked for in this cycle.
    if (w_abort) begin
      w_state_next = ST_IDLE;
      w_x_next     = '0;
      w_round_next = '0;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 3: outputs (Moore, from registered state only)
  // -------------------------------------------------------------------------
  always_comb begin
    w_in_ready  = 1'b0;
    w_key_req   = 1'b0;
    w_key_idx   = 6'd0;
    w_out_valid = 1'b0;
    w_y         = '0;
    w_busy      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
      end
      ST_RUN: begin
        w_key_req = 1'b1;
        w_key_idx = r_round;
        w_busy    = 1'b1;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        w_y         = r_x;
        w_busy      = 1'b1;
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.key_req   = w_key_req;
  assign bus.key_idx   = w_key_idx;
  assign bus.out_valid = w_out_valid;
  assign bus.y0        = w_y[0];
  assign bus.y1        = w_y[1];
  assign bus.y2        = w_y[2];
  assign bus.y3        = w_y[3];
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_serpent_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serpent_round_ctrl
//
// Directed bench for serpent_round_ctrl. The bench acts as the front end,
// the key-schedule RAM and the ciphertext consumer. Expected ciphertexts come
// from a software model and go into a queue when a block is offered. Each
// one is popped and compared when out_valid appears.
// ---------------------------------------------------------------------------
module tb_serpent_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serpent_round_ctrl_if bus_if ();

`ifdef SERPENT_CTRL_ABORT_EN
  logic abort;
`endif

  serpent_round_ctrl dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SERPENT_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  int blk_no   = 0;

  logic [127:0] exp_q[$];
  logic [31:0]  key_mem [0:32][0:3];
  int           stall   [0:33];
  logic [63:0]  sbox_tab [0:7];

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Software model (bit-sliced Serpent)
  // -------------------------------------------------------------------------
  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [3:0] sb(input int box, input logic [3:0] v);
    logic [63:0] t;
    int          idx;
    t   = sbox_tab[box];
    idx = 60 - 4 * int'(v);
    return t[idx +: 4];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] p);
    logic [31:0] w [4];
    logic [31:0] t [4];
    logic [3:0]  nib;
    logic [3:0]  o;
    for (int n = 0; n < 4; n++) w[n] = p[32*n +: 32];
    for (int r = 0; r < 32; r++) begin
      for (int n = 0; n < 4; n++) t[n] = w[n] ^ key_mem[r][n];
      for (int i = 0; i < 32; i++) begin
        nib = {t[3][i], t[2][i], t[1][i], t[0][i]};
        o   = sb(r % 8, nib);
        for (int n = 0; n < 4; n++) w[n][i] = o[n];
      end
      if (r < 31) begin
        w[0] = rol(w[0], 13);
        w[2] = rol(w[2], 3);
        w[1] = w[1] ^ w[0] ^ w[2];
        w[3] = w[3] ^ w[2] ^ (w[0] << 3);
        w[1] = rol(w[1], 1);
        w[3] = rol(w[3], 7);
        w[0] = w[0] ^ w[1] ^ w[3];
        w[2] = w[2] ^ w[3] ^ (w[1] << 7);
        w[0] = rol(w[0], 5);
        w[2] = rol(w[2], 22);
      end
    end
    for (int n = 0; n < 4; n++) w[n] = w[n] ^ key_mem[32][n];
    return {w[3], w[2], w[1], w[0]};
  endfunction

  // -------------------------------------------------------------------------
  // Drive / sample helpers
  // -------------------------------------------------------------------------
  task automatic set_x(input logic [127:0] v);
    bus_if.x0 = v[31:0];
    bus_if.x1 = v[63:32];
    bus_if.x2 = v[95:64];
    bus_if.x3 = v[127:96];
  endtask

  task automatic set_k(input int r);
    bus_if.k0 = key_mem[r][0];
    bus_if.k1 = key_mem[r][1];
    bus_if.k2 = key_mem[r][2];
    bus_if.k3 = key_mem[r][3];
  endtask

  task automatic set_k_junk();
    bus_if.k0 = $urandom;
    bus_if.k1 = $urandom;
    bus_if.k2 = $urandom;
    bus_if.k3 = $urandom;
  endtask

  function automatic logic [127:0] get_y();
    return {bus_if.y3, bus_if.y2, bus_if.y1, bus_if.y0};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offers pt, serves all 33 subkeys (with stall[r] unacknowledged cycles
  // before round r), then holds out_ready low for out_wait cycles.
  // With hold_next, in_valid stays high with nxt after the accept edge.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] nxt,
                           input bit hold_next, input int out_wait);
    logic [127:0] exp_ct;
    check("idle_in_ready", 128'(bus_if.in_ready), 128'd1);
    bus_if.in_valid = 1'b1;
    set_x(pt);
    exp_q.push_back(model(pt));
    tick();
    if (hold_next) set_x(nxt);
    else bus_if.in_valid = 1'b0;
    check("accept_busy", 128'(bus_if.busy), 128'd1);
    check("accept_in_ready", 128'(bus_if.in_ready), 128'd0);
    for (int r = 0; r <= 32; r++) begin
      for (int s = 0; s < stall[r]; s++) begin
        check("stall_key_req", 128'(bus_if.key_req), 128'd1);
        check("stall_key_idx", 128'(bus_if.key_idx), 128'(r));
        bus_if.key_ack = 1'b0;
        set_k_junk();
        tick();
      end
      check("run_key_req", 128'(bus_if.key_req), 128'd1);
      check("run_key_idx", 128'(bus_if.key_idx), 128'(r));
      check("run_out_valid", 128'(bus_if.out_valid), 128'd0);
      bus_if.key_ack = 1'b1;
      set_k(r);
      tick();
    end
    bus_if.key_ack = 1'b0;
    set_k_junk();
    check("done_out_valid", 128'(bus_if.out_valid), 128'd1);
    check("done_key_req", 128'(bus_if.key_req), 128'd0);
    exp_ct = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    check("ciphertext", get_y(), exp_ct);
    $display("block %0d pt=%h ct=%h exp=%h", blk_no, pt, get_y(), exp_ct);
    blk_no++;
    for (int w = 0; w < out_wait; w++) begin
      bus_if.out_ready = 1'b0;
      bus_if.key_ack   = 1'b1;  // must be ignored outside RUN
      tick();
      check("hold_out_valid", 128'(bus_if.out_valid), 128'd1);
      check("hold_y", get_y(), exp_ct);
      check("hold_in_ready", 128'(bus_if.in_ready), 128'd0);
      check("hold_key_req", 128'(bus_if.key_req), 128'd0);
    end
    bus_if.key_ack   = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    check("post_out_valid", 128'(bus_if.out_valid), 128'd0);
    check("post_in_ready", 128'(bus_if.in_ready), 128'd1);
    check("post_busy", 128'(bus_if.busy), 128'd0);
    check("post_key_req", 128'(bus_if.key_req), 128'd0);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin : main
    logic [127:0] pa;
    logic [127:0] pb;

    sbox_tab[0] = 64'h38F1A65BED42709C;
    sbox_tab[1] = 64'hFC27905A1BE86D34;
    sbox_tab[2] = 64'h86793CAFD1E40B52;
    sbox_tab[3] = 64'h0FB8C963D124A75E;
    sbox_tab[4] = 64'h1F83C0B6254A9E7D;
    sbox_tab[5] = 64'hF52B4A9C03E8D671;
    sbox_tab[6] = 64'h72C5846BE91FD3A0;
    sbox_tab[7] = 64'h1DF0E82B74CA9356;
    for (int r = 0; r <= 32; r++) begin
      for (int n = 0; n < 4; n++) key_mem[r][n] = 32'd0;
    end
    for (int r = 0; r <= 33; r++) stall[r] = 0;

    rst              = 1'b1;
    bus_if.in_valid  = 1'b1;   // must be ignored during reset
    bus_if.key_ack   = 1'b0;
    bus_if.out_ready = 1'b0;
    set_x(rnd128());
    set_k(0);
`ifdef SERPENT_CTRL_ABORT_EN
    abort = 1'b0;
`endif

    // Reset values
    repeat (3) tick();
    check("rst_in_ready", 128'(bus_if.in_ready), 128'd1);
    check("rst_key_req", 128'(bus_if.key_req), 128'd0);
    check("rst_key_idx", 128'(bus_if.key_idx), 128'd0);
    check("rst_out_valid", 128'(bus_if.out_valid), 128'd0);
    check("rst_y", get_y(), 128'd0);
    check("rst_busy", 128'(bus_if.busy), 128'd0);
    rst             = 1'b0;
    bus_if.in_valid = 1'b0;
    set_x(128'd0);

    // key_ack with no request outstanding is ignored
    bus_if.key_ack = 1'b1;
    repeat (2) tick();
    bus_if.key_ack = 1'b0;
    check("idle_ack_busy", 128'(bus_if.busy), 128'd0);
    check("idle_ack_key_req", 128'(bus_if.key_req), 128'd0);

    // Zero plaintext, zero keys, key_ack every cycle
    run_block(128'd0, 128'd0, 1'b0, 0);

    // Random plaintext and keys, no stalls, then the same with stalls
    for (int r = 0; r <= 32; r++) begin
      for (int n = 0; n < 4; n++) key_mem[r][n] = $urandom;
    end
    pa = rnd128();
    run_block(pa, 128'd0, 1'b0, 0);
    stall[0]  = 3;
    stall[7]  = 3;
    stall[32] = 3;
    run_block(pa, 128'd0, 1'b0, 5);
    stall[0]  = 0;
    stall[7]  = 0;
    stall[32] = 0;

    // Back-to-back: in_valid held high across two blocks
    pa = rnd128();
    pb = rnd128();
    run_block(pa, pb, 1'b1, 0);
    run_block(pb, 128'd0, 1'b0, 2);

    // Reset in the middle of RUN at r=10
    bus_if.in_valid = 1'b1;
    set_x(rnd128());
    tick();
    bus_if.in_valid = 1'b0;
    for (int r = 0; r < 10; r++) begin
      bus_if.key_ack = 1'b1;
      set_k(r);
      tick();
    end
    check("mid_key_idx", 128'(bus_if.key_idx), 128'd10);
    rst             = 1'b1;
    bus_if.in_valid = 1'b1;
    tick();
    check("midrst_in_ready", 128'(bus_if.in_ready), 128'd1);
    check("midrst_key_req", 128'(bus_if.key_req), 128'd0);
    check("midrst_out_valid", 128'(bus_if.out_valid), 128'd0);
    check("midrst_y", get_y(), 128'd0);
    tick();
    rst             = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.key_ack  = 1'b0;
    check("midrst_busy", 128'(bus_if.busy), 128'd0);
    check("midrst_key_idx", 128'(bus_if.key_idx), 128'd0);

    // A block after the reset still encrypts correctly
    run_block(rnd128(), 128'd0, 1'b0, 1);

`ifdef SERPENT_CTRL_ABORT_EN
    // Abort at r=5 together with key_ack
    bus_if.in_valid = 1'b1;
    set_x(rnd128());
    tick();
    bus_if.in_valid = 1'b0;
    for (int r = 0; r < 5; r++) begin
      bus_if.key_ack = 1'b1;
      set_k(r);
      tick();
    end
    check("abort_pre_idx", 128'(bus_if.key_idx), 128'd5);
    bus_if.key_ack = 1'b1;
    set_k(5);
    abort = 1'b1;
    tick();
    abort          = 1'b0;
    bus_if.key_ack = 1'b0;
    check("abort_in_ready", 128'(bus_if.in_ready), 128'd1);
    check("abort_key_req", 128'(bus_if.key_req), 128'd0);
    check("abort_out_valid", 128'(bus_if.out_valid), 128'd0);
    check("abort_busy", 128'(bus_if.busy), 128'd0);
    run_block(rnd128(), 128'd0, 1'b0, 0);
`endif

    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
